// File: rtl/mem_wr_arbiter.sv
`default_nettype none
// ============================================================================
// mem_wr_arbiter : port-A write scheduler for the ROM/RAM DPRAMs
//                  (downloader, eraser and buffered CPU writes)
// Revision 1.0
// ============================================================================
module mem_wr_arbiter #(
  parameter int          CPU_FIFO_DEPTH = 4,
  parameter logic [24:0] ROM_LIMIT      = 25'h08000,
  parameter logic [24:0] RAM_BASE       = 25'h10000,
  parameter logic [24:0] RAM_LIMIT      = 25'h20000,
  parameter int          STARVE_MAX     = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_req,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ack,
  input  logic        er_req,
  input  logic [24:0] er_addr,
  input  logic [7:0]  er_data,
  output logic        er_ack,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        rom_enabled,
  output logic        cpu_full,
  output logic        cpu_ovf,
  output logic        busy,
  output logic        rom_wr,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        ram_wr,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data
);

  localparam int PTR_W = (CPU_FIFO_DEPTH > 1) ? $clog2(CPU_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CPU_FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DL   = 2'd1,
    GNT_ER   = 2'd2,
    GNT_CPU  = 2'd3
  } grant_t;

  logic             dl_ack_q, er_ack_q;
  logic             rom_wr_q, ram_wr_q;
  logic [14:0]      rom_addr_q;
  logic [7:0]       rom_data_q;
  logic [15:0]      ram_addr_q;
  logic [7:0]       ram_data_q;
  logic             cpu_ovf_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [15:0]      fifo_addr_q [CPU_FIFO_DEPTH];
  logic [7:0]       fifo_data_q [CPU_FIFO_DEPTH];

  grant_t      grant;
  logic        fifo_nonempty, fifo_full;
  logic        push, push_ok, pop, drop;
  logic        is_ext, hit_rom, hit_ram;
  logic [24:0] sel_addr;
  logic [7:0]  sel_data;

  assign fifo_nonempty = (cnt_q != '0);
  assign fifo_full     = (cnt_q == FULL_CNT);

  // A requester acked this cycle is masked so a still-held req is not granted twice
  always_comb begin
    grant = GNT_NONE;
    if (fifo_nonempty && (starve_q >= STV_LIM)) grant = GNT_CPU;
    else if (dl_req && !dl_ack_q)               grant = GNT_DL;
    else if (er_req && !er_ack_q)               grant = GNT_ER;
    else if (fifo_nonempty)                     grant = GNT_CPU;
  end

  assign sel_addr = (grant == GNT_ER) ? er_addr : dl_addr;
  assign sel_data = (grant == GNT_ER) ? er_data : dl_data;
  assign is_ext   = (grant == GNT_DL) || (grant == GNT_ER);
  assign hit_rom  = (sel_addr < ROM_LIMIT);
  assign hit_ram  = (sel_addr >= RAM_BASE) && (sel_addr < RAM_LIMIT);

  assign pop     = (grant == GNT_CPU);
  assign push    = cpu_wr && (!rom_enabled || (cpu_addr >= 16'h8000));
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    starve_d = starve_q;
    if (!fifo_nonempty || pop)  starve_d = '0;
    else if (starve_q < STV_LIM) starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_ack_q   <= 1'b0;
      er_ack_q   <= 1'b0;
      rom_wr_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      cpu_ovf_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
    end else begin
      dl_ack_q <= (grant == GNT_DL);
      er_ack_q <= (grant == GNT_ER);
      rom_wr_q <= is_ext && hit_rom;
      ram_wr_q <= (is_ext && hit_ram) || pop;
      if (is_ext && hit_rom) begin
        rom_addr_q <= sel_addr[14:0];
        rom_data_q <= sel_data;
      end
      if (is_ext && hit_ram) begin
        ram_addr_q <= sel_addr[15:0];
        ram_data_q <= sel_data;
      end else if (pop) begin
        ram_addr_q <= fifo_addr_q[rd_ptr_q];
        ram_data_q <= fifo_data_q[rd_ptr_q];
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop)    cpu_ovf_q <= 1'b1;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_data;
    end
  end

  assign dl_ack   = dl_ack_q;
  assign er_ack   = er_ack_q;
  assign rom_wr   = rom_wr_q;
  assign rom_addr = rom_addr_q;
  assign rom_data = rom_data_q;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign cpu_ovf  = cpu_ovf_q;
  assign cpu_full = fifo_full;
  assign busy     = fifo_nonempty || rom_wr_q || ram_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_wr_arbiter : directed bench for mem_wr_arbiter with write scoreboard
// Revision 1.0
// ============================================================================
module tb_mem_wr_arbiter;

  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 rom, 2 ram
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_req, er_req, cpu_wr, rom_enabled;
  logic [24:0] dl_addr, er_addr;
  logic [7:0]  dl_data, er_data, cpu_data;
  logic [15:0] cpu_addr;
  logic        dl_ack, er_ack, cpu_full, cpu_ovf, busy;
  logic        rom_wr, ram_wr;
  logic [14:0] rom_addr;
  logic [15:0] ram_addr;
  logic [7:0]  rom_data, ram_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_dl_ack = 0;
  int   n_er_ack = 0;
  int   n_cpu_wr = 0;
  int   first_cpu;
  int   snap;
  exp_t q_dl[$], q_er[$], q_cpu[$];
  exp_t hold_dl, hold_er;

  mem_wr_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .er_req(er_req), .er_addr(er_addr), .er_data(er_data), .er_ack(er_ack),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .rom_enabled(rom_enabled), .cpu_full(cpu_full), .cpu_ovf(cpu_ovf), .busy(busy),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    e.data = d;
    if (a < 25'h08000) begin
      e.kind = 2'd1; e.addr = {1'b0, a[14:0]};
    end else if (a >= 25'h10000 && a < 25'h20000) begin
      e.kind = 2'd2; e.addr = a[15:0];
    end else begin
      e.kind = 2'd0; e.addr = 16'h0;
    end
    return e;
  endfunction

  task automatic cmp_ext(input string tag, input exp_t e);
    check({tag, "_rom_wr"}, 32'(rom_wr), 32'(e.kind == 2'd1));
    check({tag, "_ram_wr"}, 32'(ram_wr), 32'(e.kind == 2'd2));
    if (e.kind == 2'd1) begin
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'(e.addr[14:0]));
      check({tag, "_rom_data"}, 32'(rom_data), 32'(e.data));
    end else if (e.kind == 2'd2) begin
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'(e.addr));
      check({tag, "_ram_data"}, 32'(ram_data), 32'(e.data));
    end
  endtask

  // Write monitor: every issued write is matched against its source's queue
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (rom_wr && ram_wr) check("dual_strobe", 32'(1), 32'(0));
      if (dl_ack && er_ack) check("dual_ack", 32'(1), 32'(0));
      if (dl_ack) begin
        n_dl_ack++;
        check("dl_sb_avail", 32'(q_dl.size() != 0), 32'(1));
        if (q_dl.size() != 0) cmp_ext("dl", q_dl.pop_front());
      end else if (er_ack) begin
        n_er_ack++;
        check("er_sb_avail", 32'(q_er.size() != 0), 32'(1));
        if (q_er.size() != 0) cmp_ext("er", q_er.pop_front());
      end else if (rom_wr || ram_wr) begin
        n_cpu_wr++;
        check("cpu_sb_avail", 32'(q_cpu.size() != 0), 32'(1));
        if (q_cpu.size() != 0) cmp_ext("cpu", q_cpu.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    int i;
    q_dl.push_back(mk(a, d));
    dl_req = 1'b1; dl_addr = a; dl_data = d;
    for (i = 0; i < 20; i++) begin
      tick();
      if (dl_ack) break;
    end
    check("dl_ack_timeout", 32'(dl_ack), 32'(1));
    dl_req = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      tick();
      if (!busy) break;
    end
    check("idle_timeout", 32'(busy), 32'(0));
    tick();
  endtask

  task automatic hold_start();
    hold_dl = mk(25'h00100, 8'h11);
    hold_er = mk(25'h10200, 8'h22);
    dl_addr = 25'h00100; dl_data = 8'h11;
    er_addr = 25'h10200; er_data = 8'h22;
    q_dl.push_back(hold_dl);
    q_er.push_back(hold_er);
    dl_req = 1'b1; er_req = 1'b1;
  endtask

  // dl and er held together alternate grants, so the CPU only wins via starvation
  task automatic hold_run(input int n, input int npush, input int nexp, input logic [15:0] base);
    first_cpu = -1;
    for (int i = 0; i < n; i++) begin
      if (i < npush) begin
        cpu_wr = 1'b1; cpu_addr = base + 16'(i); cpu_data = 8'h40 + 8'(i);
        if (i < nexp) q_cpu.push_back({2'd2, base + 16'(i), 8'h40 + 8'(i)});
      end else begin
        cpu_wr = 1'b0;
      end
      tick();
      cpu_wr = 1'b0;
      if (dl_ack) q_dl.push_back(hold_dl);
      if (er_ack) q_er.push_back(hold_er);
      if (first_cpu < 0 && ram_wr && !dl_ack && !er_ack) first_cpu = i;
    end
  endtask

  task automatic hold_stop();
    dl_req = 1'b0; er_req = 1'b0;
    tick();
    q_dl.delete();
    q_er.delete();
  endtask

  initial begin
    reset = 1'b1;
    dl_req = 1'b0; er_req = 1'b0; cpu_wr = 1'b0; rom_enabled = 1'b0;
    dl_addr = '0; er_addr = '0; dl_data = '0; er_data = '0;
    cpu_addr = '0; cpu_data = '0;
    repeat (3) tick();
    check("rst_strobes", 32'({rom_wr, ram_wr, dl_ack, er_ack}), 32'(0));
    check("rst_flags", 32'({cpu_full, cpu_ovf, busy}), 32'(0));
    check("rst_addr", 32'({rom_addr, ram_addr}), 32'(0));
    reset = 1'b0;
    tick();

    // Single ROM write, latency one cycle
    q_dl.push_back(mk(25'h00010, 8'hA5));
    dl_req = 1'b1; dl_addr = 25'h00010; dl_data = 8'hA5;
    tick();
    check("t1_rom_wr", 32'(rom_wr), 32'(1));
    check("t1_rom_addr", 32'(rom_addr), 32'(15'h0010));
    check("t1_dl_ack", 32'(dl_ack), 32'(1));
    dl_req = 1'b0;
    tick();
    check("t1_ack_pulse", 32'({dl_ack, rom_wr}), 32'(0));

    // dl and er together: dl first, er one cycle later
    q_dl.push_back(mk(25'h00020, 8'h5A));
    q_er.push_back(mk(25'h10020, 8'hC3));
    dl_req = 1'b1; dl_addr = 25'h00020; dl_data = 8'h5A;
    er_req = 1'b1; er_addr = 25'h10020; er_data = 8'hC3;
    tick();
    check("t2_c1_acks", 32'({dl_ack, er_ack}), 32'(2'b10));
    dl_req = 1'b0;
    tick();
    check("t2_c2_acks", 32'({dl_ack, er_ack}), 32'(2'b01));
    er_req = 1'b0;
    tick();
    check("t2_c3_acks", 32'({dl_ack, er_ack}), 32'(2'b00));

    // Address decode
    dl_write(25'h12345, 8'h3C);
    dl_write(25'h0C000, 8'h99);
    dl_write(25'h20000, 8'h77);
    dl_write(25'h07FFF, 8'h01);
    dl_write(25'h1FFFF, 8'h02);
    tick();
    check("t3_dl_acks", 32'(n_dl_ack), 32'(7));
    check("t3_er_acks", 32'(n_er_ack), 32'(1));

    // Starvation: 3 CPU writes under continuous dl/er pressure
    snap = n_cpu_wr;
    hold_start();
    hold_run(40, 3, 3, 16'h9000);
    check("t4_starve_latency", 32'(first_cpu >= 0 && first_cpu <= STARVE_MAX + 2), 32'(1));
    hold_stop();
    wait_idle();
    check("t4_cpu_count", 32'(n_cpu_wr - snap), 32'(3));
    check("t4_cpu_sb_empty", 32'(q_cpu.size()), 32'(0));

    // Overflow: 5 pushes into a 4-deep FIFO while blocked
    snap = n_cpu_wr;
    hold_start();
    hold_run(5, 5, 4, 16'hA000);
    check("t5_full", 32'(cpu_full), 32'(1));
    check("t5_ovf", 32'(cpu_ovf), 32'(1));
    hold_stop();
    wait_idle();
    check("t5_cpu_count", 32'(n_cpu_wr - snap), 32'(4));
    check("t5_ovf_sticky", 32'(cpu_ovf), 32'(1));
    check("t5_not_full", 32'(cpu_full), 32'(0));

    // ROM protection filters low CPU writes only
    snap = n_cpu_wr;
    rom_enabled = 1'b1;
    cpu_wr = 1'b1; cpu_addr = 16'h1000; cpu_data = 8'hEE;
    tick();
    cpu_wr = 1'b0;
    check("t6_no_push", 32'(busy), 32'(0));
    repeat (3) tick();
    check("t6_no_write", 32'(n_cpu_wr - snap), 32'(0));
    q_cpu.push_back({2'd2, 16'h8010, 8'h77});
    cpu_wr = 1'b1; cpu_addr = 16'h8010; cpu_data = 8'h77;
    tick();
    cpu_wr = 1'b0;
    check("t6_push_busy", 32'(busy), 32'(1));
    wait_idle();
    check("t6_hi_write", 32'(n_cpu_wr - snap), 32'(1));
    rom_enabled = 1'b0;

    // Asynchronous reset with 2 entries queued discards them
    hold_start();
    hold_run(4, 2, 2, 16'hB000);
    check("t7_queued", 32'(busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("t7_rst_strobes", 32'({rom_wr, ram_wr, dl_ack, er_ack}), 32'(0));
    check("t7_rst_flags", 32'({cpu_full, cpu_ovf, busy}), 32'(0));
    dl_req = 1'b0; er_req = 1'b0;
    q_dl.delete(); q_er.delete(); q_cpu.delete();
    snap = n_cpu_wr;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("t7_no_cpu_after_rst", 32'(n_cpu_wr - snap), 32'(0));
    check("t7_idle", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
